// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters with a 3-state sequencer.
// ALU_ARB_RR_EN selects round-robin tie-break; undefined gives fixed req0 priority.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,

    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,

    output logic              busy
);

    // state | meaning
    // IDLE  | arbitrate between requesters, accept one operation
    // EXEC  | registered operands drive the ALU, result captured at cycle end
    // RESP  | result presented to the owner until it takes it
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] result_q;

    logic grant;
    logic idle_open;
    logic accept;
    logic rsp_take;

`ifdef ALU_ARB_RR_EN
    logic last_served;

    always_comb begin
        grant = !req0_valid;
        if (req0_valid && req1_valid) begin
            grant = !last_served;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= 1'b1;
        end else if (state == RESP && rsp_take) begin
            last_served <= owner;
        end
    end
`else
    always_comb begin
        grant = !req0_valid;
    end
`endif

    // Ready is held low during reset so no handshake can complete while rst is high.
    assign idle_open  = (state == IDLE) && !rst;
    assign req0_ready = idle_open && req0_valid && !grant;
    assign req1_ready = idle_open && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner  <= grant;
                        op1_q  <= grant ? req1_op1  : req0_op1;
                        op2_q  <= grant ? req1_op2  : req0_op2;
                        ctrl_q <= grant ? req1_ctrl : req0_ctrl;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_out;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp0_data  = rsp0_valid ? result_q : '0;
    assign rsp1_data  = rsp1_valid ? result_q : '0;

    assign alu_op1  = op1_q;
    assign alu_op2  = op2_q;
    assign alu_ctrl = ctrl_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a transaction-level reference (phase count since acceptance,
// owner, expected result from a behavioural ALU) predicts every output each cycle.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] alu_op1, alu_op2, alu_out;
    logic [3:0]  alu_ctrl;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // RV32 AluContrl codes
    localparam logic [3:0] C_SLL = 4'd0, C_SRL = 4'd1, C_SRA = 4'd2, C_ADD = 4'd3,
                           C_SUB = 4'd4, C_XOR = 4'd5, C_OR = 4'd6, C_AND = 4'd7,
                           C_SLT = 4'd8, C_SLTU = 4'd9, C_LUI = 4'd10;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        case (c)
            C_SLL:   return a << b[4:0];
            C_SRL:   return a >> b[4:0];
            C_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_XOR:   return a ^ b;
            C_OR:    return a | b;
            C_AND:   return a & b;
            C_SLT:   return {31'b0, $signed(a) < $signed(b)};
            C_SLTU:  return {31'b0, a < b};
            C_LUI:   return b;
            default: return 32'hDEAD_BEEF ^ a;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_op1, alu_op2, alu_ctrl);

    alu_share_arb #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
        .busy(busy)
    );

    // Reference model: m_phase is cycles since acceptance (0 = idle).
    int          m_phase;
    logic        m_owner, m_last;
    logic [31:0] m_result, m_a, m_b;
    logic [3:0]  m_c;
    logic        p_accept, p_grant;
    logic [136:0] exp_vec;

    function automatic logic pick();
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
            return (m_last == 1'b0);
`else
            return 1'b0;
`endif
        end
        return req1_valid;
    endfunction

    function automatic logic [136:0] obs_vec();
        return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy,
                rsp0_data, rsp1_data, alu_op1, alu_op2, alu_ctrl};
    endfunction

    task automatic predict();
        logic idle, r0, r1, v0, v1;
        #1;
        idle     = (m_phase == 0);
        p_grant  = pick();
        p_accept = idle && !rst && (req0_valid || req1_valid);
        r0 = p_accept && !p_grant;
        r1 = p_accept && p_grant;
        v0 = (m_phase >= 2) && !m_owner;
        v1 = (m_phase >= 2) && m_owner;
        exp_vec = {r0, r1, v0, v1, !idle,
                   v0 ? m_result : 32'h0, v1 ? m_result : 32'h0, m_a, m_b, m_c};
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_last = 1'b1; m_owner = 1'b0;
            m_a = '0; m_b = '0; m_c = '0; m_result = '0;
        end else if (m_phase == 0) begin
            if (p_accept) begin
                m_owner = p_grant;
                m_a = p_grant ? req1_op1 : req0_op1;
                m_b = p_grant ? req1_op2 : req0_op2;
                m_c = p_grant ? req1_ctrl : req0_ctrl;
                m_result = alu_ref(m_a, m_b, m_c);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_phase = 0;
            m_last  = m_owner;
        end else begin
            m_phase = m_phase + 1;
        end
        @(negedge clk);
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c);
        req0_valid = v; req0_op1 = a; req0_op2 = b; req0_ctrl = c;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c);
        req1_valid = v; req1_op1 = a; req1_op2 = b; req1_ctrl = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req0($urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
            set_req1($urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            advance();
        end
        rst = 1'b0;
        set_req0(1'b0, 0, 0, 0);
        set_req1(1'b0, 0, 0, 0);
        predict();
        n_tests++;
        if (obs_vec() !== 137'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want 0", obs_vec());
        end
        advance();
    endtask

    task automatic test_single();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_req0(i == 0, 32'd5, 32'd7, C_ADD);
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL single cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            if (i == 2) begin
                n_tests++;
                if (!(rsp0_valid === 1'b1 && rsp0_data === 32'd12 && rsp1_valid === 1'b0)) begin
                    n_fail++;
                    $display("FAIL single_add: got v=%b d=%h want v=1 d=0000000c", rsp0_valid, rsp0_data);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 9; i++) begin
            set_req1(i == 0, 32'd3, 32'd5, C_SUB);
            set_req0(i >= 1 && i <= 5, $urandom, $urandom, C_ADD);
            rsp1_ready = (i >= 6);
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL backpressure cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            if (i >= 2 && i <= 5) begin
                n_tests++;
                if (!(rsp1_valid === 1'b1 && rsp1_data === 32'hFFFF_FFFE && busy === 1'b1 &&
                      req0_ready === 1'b0 && req1_ready === 1'b0)) begin
                    n_fail++;
                    $display("FAIL backpressure_hold cyc%0d: got v=%b d=%h busy=%b want v=1 d=fffffffe busy=1",
                             i, rsp1_valid, rsp1_data, busy);
                end
            end
            advance();
        end
        set_req0(1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL backpressure_drain cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_tie();
        logic gq[$];
        rst = 1'b1; predict(); advance(); rst = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        set_req0(1'b1, 32'hFFFF_FFFF, 32'd1, C_SLT);
        set_req1(1'b1, 32'hFFFF_FFFF, 32'd1, C_SLTU);
        for (int i = 0; i < 15; i++) begin
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL tie cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            if (req0_ready === 1'b1) gq.push_back(1'b0);
            if (req1_ready === 1'b1) gq.push_back(1'b1);
            if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
                n_tests++;
                if ((rsp0_valid === 1'b1 && rsp0_data !== 32'd1) ||
                    (rsp1_valid === 1'b1 && rsp1_data !== 32'd0)) begin
                    n_fail++;
                    $display("FAIL tie_result cyc%0d: got d0=%h d1=%h want d0=1 d1=0", i, rsp0_data, rsp1_data);
                end
            end
            advance();
        end
        n_tests++;
        if (gq.size() != 5) begin
            n_fail++;
            $display("FAIL tie_count: got %0d grants want 5", gq.size());
        end
        for (int k = 0; k < gq.size(); k++) begin
            logic want;
`ifdef ALU_ARB_RR_EN
            want = (k % 2) == 1;
`else
            want = 1'b0;
`endif
            n_tests++;
            if (gq[k] !== want) begin
                n_fail++;
                $display("FAIL tie_grant%0d: got %0d want %0d", k, gq[k], want);
            end
        end
        set_req0(1'b0, 0, 0, 0);
        set_req1(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            predict(); advance();
        end
    endtask

    task automatic test_reset_mid();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 0)      set_req0(1'b1, 32'hF0F0_F0F0, 32'hFFFF_FFFF, C_XOR);
            else if (i == 2) set_req0(1'b1, 32'h1234_0000, 32'h0000_5678, C_OR);
            else             set_req0(1'b0, 0, 0, 0);
            rst = (i == 1);
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            if (i == 2) begin
                n_tests++;
                if (!(rsp0_valid === 1'b0 && busy === 1'b0 && alu_op1 === 32'h0 && alu_op2 === 32'h0)) begin
                    n_fail++;
                    $display("FAIL reset_mid_clear: got v=%b busy=%b op1=%h want all 0", rsp0_valid, busy, alu_op1);
                end
            end
            if (i == 4) begin
                n_tests++;
                if (!(rsp0_valid === 1'b1 && rsp0_data === 32'h1234_5678)) begin
                    n_fail++;
                    $display("FAIL reset_mid_next: got v=%b d=%h want v=1 d=12345678", rsp0_valid, rsp0_data);
                end
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_withdraw();
        int acc1, rsp1_seen;
        acc1 = 0; rsp1_seen = 0;
        for (int i = 0; i < 9; i++) begin
            set_req0(i == 0, $urandom, $urandom, C_AND);
            set_req1(i == 3, $urandom, $urandom, C_ADD);
            rsp0_ready = (i >= 4);
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL withdraw cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            if (req1_ready === 1'b1) acc1++;
            if (rsp1_valid === 1'b1) rsp1_seen++;
            advance();
        end
        n_tests++;
        if (acc1 != 0 || rsp1_seen != 0) begin
            n_fail++;
            $display("FAIL withdraw_effect: got acc=%0d rsp=%0d want 0 0", acc1, rsp1_seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_req0($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom));
            set_req1($urandom_range(0, 2) != 0, $urandom, $urandom, 4'($urandom));
            rsp0_ready = $urandom_range(0, 2) != 0;
            rsp1_ready = $urandom_range(0, 2) != 0;
            predict();
            n_tests++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_req0(1'b0, 0, 0, 0);
        set_req1(1'b0, 0, 0, 0);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        m_phase = 0; m_last = 1'b1; m_owner = 1'b0;
        m_a = '0; m_b = '0; m_c = '0; m_result = '0;
        p_accept = 1'b0; p_grant = 1'b0;
        @(negedge clk);
        advance();
        test_reset();
        test_single();
        test_back_pressure();
        test_tie();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
